// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Purpose:
//   Single-outstanding-request instruction fetch stage. It requests the word
//   at pc, registers the returned instruction, and presents it to decode
//   with a valid/ready handshake. When decode accepts the instruction, the
//   stage moves pc to the branch target or to pc+4. It also counts accepted
//   instructions.
//
// Optional feature (compile-time macro IFETCH_MISALIGN_TRAP_EN):
//   defined   - a taken branch to a target that is not word aligned sets the
//               sticky misalign_err flag, loads the raw target into pc and
//               parks the stage in S_HALT until reset.
//   undefined - misalign_err and S_HALT do not exist. The two low bits of
//               the branch target are cleared when the target is loaded
//               into pc.
//
// Ports:
//   clk            in   1   single clock, rising edge
//   rst_n          in   1   synchronous active-low reset
//   imem_req       out  1   fetch request to instruction memory
//   imem_addr      out  32  fetch address (always equals pc)
//   imem_rdata     in   32  instruction word from memory
//   imem_rvalid    in   1   imem_rdata valid this cycle
//   instr          out  32  registered instruction word for decode
//   instr_valid    out  1   instr/pc valid for decode
//   instr_ready    in   1   decode accepts instr this cycle
//   branch_taken   in   1   accepted instruction redirects the pc
//   branch_target  in   32  redirect address
//   pc             out  32  address of the word held in instr
//   instr_count    out  32  instructions accepted since reset (wraps)
//   misalign_err   out  1   sticky misaligned-target flag (macro only)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
`ifdef IFETCH_MISALIGN_TRAP_EN
    output logic [31:0] instr_count,
    output logic        misalign_err
`else
    output logic [31:0] instr_count
`endif
);

    // addi x0, x0, 0: decode sees a harmless word before the first fetch.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,   // request outstanding, waiting for imem_rvalid
`ifdef IFETCH_MISALIGN_TRAP_EN
        S_VALID = 2'd1,   // instr presented, waiting for instr_ready
        S_HALT  = 2'd2    // misaligned branch trapped, idle until reset
`else
        S_VALID = 2'd1    // instr presented, waiting for instr_ready
`endif
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] count_q;
    logic        capture;     // latch imem_rdata this cycle
    logic        handshake;   // decode accepts the instruction this cycle
    logic [31:0] pc_next;     // pc value loaded on handshake
    logic [31:0] branch_pc;   // branch target as loaded into pc

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        misalign_q;
    logic        trap;        // taken branch to an unaligned target

    assign trap      = branch_taken && (branch_target[1:0] != 2'b00);
    // The raw target is kept so the offending address is still visible on pc.
    assign branch_pc = branch_target;
`else
    // The low bits are dropped by design. This reduction exists only so the
    // bits are visibly consumed.
    logic unused_target_lsbs;

    assign unused_target_lsbs = ^branch_target[1:0];
    assign branch_pc          = {branch_target[31:2], 2'b00};
`endif

    // Sequential pc increment wraps at 2^32 through the 32-bit add.
    assign pc_next = branch_taken ? branch_pc : (pc_q + 32'd4);

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        handshake   = 1'b0;

        case (state_q)
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_rvalid) begin
                    capture = 1'b1;
                    state_d = S_VALID;
                end
            end

            S_VALID: begin
                // Responses arriving here belong to no request and are dropped.
                instr_valid = 1'b1;
                if (instr_ready) begin
                    handshake = 1'b1;
`ifdef IFETCH_MISALIGN_TRAP_EN
                    state_d   = trap ? S_HALT : S_REQ;
`else
                    state_d   = S_REQ;
`endif
                end
            end

`ifdef IFETCH_MISALIGN_TRAP_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the values from before the edge, whatever the statement order.
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            count_q    <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;

            if (capture) begin
                instr_q <= imem_rdata;
            end

            if (handshake) begin
                pc_q    <= pc_next;
                count_q <= count_q + 32'd1;
`ifdef IFETCH_MISALIGN_TRAP_EN
                if (trap) begin
                    misalign_q <= 1'b1;
                end
`endif
            end
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_count = count_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. A table of fetch records gives the
// memory latency, the decode stall, the branch decision, the returned word,
// the expected pc and the expected next fetch address. Each record drives
// one request/response/handshake round. The bench pushes the expected
// {instr, pc} pair when it returns a response and pops it when the DUT
// raises instr_valid. Hand-written sequences cover reset during a request
// and the misaligned branch target.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] instr_count;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_rvalid   (imem_rvalid),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
`ifdef IFETCH_MISALIGN_TRAP_EN
        .instr_count   (instr_count),
        .misalign_err  (misalign_err)
`else
        .instr_count   (instr_count)
`endif
    );

    typedef struct {
        int unsigned lat;      // request cycles before imem_rvalid
        int unsigned stall;    // cycles instr_ready is held low
        logic        br;       // branch_taken on handshake
        logic [31:0] tgt;      // branch_target on handshake
        logic [31:0] rdata;    // word returned by memory
        logic [31:0] exp_pc;   // expected fetch address / pc
        logic [31:0] exp_next; // expected address of the next fetch
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;

    sb_t         sb_q[$];
    vec_t        vecs[9];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_count = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge, and inputs for
    // the next edge are driven at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int unsigned lat, input int unsigned stall, input logic br,
                                input logic [31:0] tgt, input logic [31:0] rdata,
                                input logic [31:0] exp_pc, input logic [31:0] exp_next);
        vec_t v;
        v.lat = lat; v.stall = stall; v.br = br; v.tgt = tgt;
        v.rdata = rdata; v.exp_pc = exp_pc; v.exp_next = exp_next;
        return v;
    endfunction

    // One request/response round up to the cycle before the handshake.
    task automatic fetch_to_valid(input vec_t v);
        sb_t e;
        sb_t got;
        check("req_addr", imem_addr, v.exp_pc);
        check("req_up", {31'd0, imem_req}, 32'd1);
        check("req_no_valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < int'(v.lat); i++) begin
            imem_rvalid = 1'b0;
            tick();
            check("wait_addr", imem_addr, v.exp_pc);
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_no_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = v.rdata;
        e.instr = v.rdata;
        e.pc    = v.exp_pc;
        sb_q.push_back(e);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        check("valid_up", {31'd0, instr_valid}, 32'd1);
        check("req_down", {31'd0, imem_req}, 32'd0);
        if (instr_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL sb_empty: got instr %h with no expected entry", instr);
            end else begin
                got = sb_q.pop_front();
                check("sb_instr", instr, got.instr);
                check("sb_pc", pc, got.pc);
            end
        end
        // Decode stalls. Branch inputs and stray responses must be ignored.
        for (int i = 0; i < int'(v.stall); i++) begin
            instr_ready   = 1'b0;
            branch_taken  = 1'b1;
            branch_target = 32'h0000_0800 + 32'(i * 4);
            imem_rvalid   = 1'b1;
            imem_rdata    = 32'hBAD0_0000 | 32'(i);
            tick();
            check("stall_instr", instr, v.rdata);
            check("stall_pc", pc, v.exp_pc);
            check("stall_addr", imem_addr, v.exp_pc);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        imem_rvalid = 1'b0;
    endtask

    task automatic run_fetch(input vec_t v);
        fetch_to_valid(v);
        instr_ready   = 1'b1;
        branch_taken  = v.br;
        branch_target = v.tgt;
        tick();
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        model_count   = model_count + 32'd1;
        check("count", instr_count, model_count);
        check("next_addr", imem_addr, v.exp_next);
        check("next_req", {31'd0, imem_req}, 32'd1);
        check("next_no_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = mk(1, 0, 1'b0, 32'h0,         32'h0000_0033, 32'h0000_0000, 32'h0000_0004);
        vecs[1] = mk(0, 0, 1'b0, 32'h0,         32'h0050_0093, 32'h0000_0004, 32'h0000_0008);
        vecs[2] = mk(3, 4, 1'b0, 32'h0,         32'h4020_8133, 32'h0000_0008, 32'h0000_000C);
        vecs[3] = mk(0, 1, 1'b1, 32'h0000_0010, 32'h0000_0463, 32'h0000_000C, 32'h0000_0010);
        vecs[4] = mk(1, 2, 1'b1, 32'h0000_0040, 32'h0220_8063, 32'h0000_0010, 32'h0000_0040);
        vecs[5] = mk(2, 0, 1'b0, 32'h0,         32'h0000_006F, 32'h0000_0040, 32'h0000_0044);
        vecs[6] = mk(0, 0, 1'b1, 32'hFFFF_FFFC, 32'hFE00_0EE3, 32'h0000_0044, 32'hFFFF_FFFC);
        vecs[7] = mk(0, 0, 1'b0, 32'h0,         32'h0000_0013, 32'hFFFF_FFFC, 32'h0000_0000);
        vecs[8] = mk(0, 1, 1'b1, 32'h0000_0020, 32'h0100_0063, 32'h0000_0000, 32'h0000_0020);

        rst_n         = 1'b0;
        imem_rdata    = 32'h0;
        imem_rvalid   = 1'b0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        tick();
        tick();

        check("rst_req", {31'd0, imem_req}, 32'd1);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_count", instr_count, 32'd0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_fetch(vecs[i]);
        end

        // Reset while a request at 0x20 is outstanding; its response lands
        // on the same edge and must be discarded.
        check("pre_rst_addr", imem_addr, 32'h0000_0020);
        rst_n       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        rst_n       = 1'b1;
        imem_rvalid = 1'b0;
        model_count = '0;
        check("rst2_pc", pc, RESET_PC);
        check("rst2_instr", instr, NOP);
        check("rst2_valid", {31'd0, instr_valid}, 32'd0);
        check("rst2_count", instr_count, 32'd0);
        check("rst2_req", {31'd0, imem_req}, 32'd1);
        check("rst2_addr", imem_addr, RESET_PC);

        // Taken branch to the misaligned target 0x42.
`ifdef IFETCH_MISALIGN_TRAP_EN
        fetch_to_valid(mk(0, 0, 1'b1, 32'h0000_0042, 32'h0000_0033, 32'h0000_0000, 32'h0000_0042));
        instr_ready   = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0042;
        tick();
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_rvalid = 1'b1;
            instr_ready = 1'b1;
            check("halt_err", {31'd0, misalign_err}, 32'd1);
            check("halt_no_req", {31'd0, imem_req}, 32'd0);
            check("halt_no_valid", {31'd0, instr_valid}, 32'd0);
            check("halt_pc", pc, 32'h0000_0042);
            tick();
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("halt_rst_err", {31'd0, misalign_err}, 32'd0);
        check("halt_rst_req", {31'd0, imem_req}, 32'd1);
`else
        run_fetch(mk(0, 0, 1'b1, 32'h0000_0042, 32'h0000_0033, 32'h0000_0000, 32'h0000_0040));
        run_fetch(mk(1, 0, 1'b0, 32'h0,         32'h0000_0013, 32'h0000_0040, 32'h0000_0044));
`endif

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
